// File: rtl/ita_scan_decoder.sv
// Loopback decoder for the 12-digit 14-segment display driver: locks onto the
// scan sequence, decodes glyphs to ASCII and streams each frame over valid/ready.
module ita_scan_decoder #(
    parameter logic [7:0] GLYPH_UNKNOWN = 8'h3F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sel,
    input  logic [13:0] segm,
    input  logic        out_ready,
    input  logic        err_clr,
    output logic        out_valid,
    output logic [7:0]  out_char,
    output logic [3:0]  out_pos,
    output logic        out_last,
    output logic        locked,
    output logic [2:0]  err_flags
);

    typedef enum logic {SYNC, CAPTURE} state_t;

    state_t      state;
    logic [11:0] sel_q;
    logic [13:0] segm_q;
    logic [3:0]  exp_idx;
    logic [7:0]  cap_buf [12];
    logic [7:0]  out_buf [12];

    logic [7:0]  glyph;
    logic        glyph_known;
    logic        sel_onehot;
    logic [3:0]  sel_idx;
    logic [3:0]  prev_idx;
    logic        capture_en;
    logic        commit_req;
    logic        seq_err;
    logic        last_xfer;
    logic        commit_ok;

    always_comb begin
        glyph_known = 1'b1;
        case (segm_q)
            14'b11101111000000: glyph = 8'h41;
            14'b10011100000000: glyph = 8'h43;
            14'b10011110000000: glyph = 8'h45;
            14'b10010000010010: glyph = 8'h49;
            14'b01101100101000: glyph = 8'h4D;
            14'b01101100100100: glyph = 8'h4E;
            14'b10000000010010: glyph = 8'h54;
            14'b00000000000000: glyph = 8'h20;
            default: begin
                glyph       = GLYPH_UNKNOWN;
                glyph_known = 1'b0;
            end
        endcase
    end

    always_comb begin
        sel_onehot = (sel_q != 12'h000) && ((sel_q & (sel_q - 12'd1)) == 12'h000);
        sel_idx    = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (sel_q[k]) sel_idx = 4'(k);
        end
        prev_idx = (exp_idx == 4'd0) ? 4'd11 : exp_idx - 4'd1;
    end

    // A repeat of the previously captured digit is the driver holding a digit
    // for more than one clock and is not an error.
    always_comb begin
        capture_en = 1'b0;
        commit_req = 1'b0;
        seq_err    = 1'b0;
        if (state == SYNC) begin
            capture_en = (sel_q == 12'h001);
        end else if (sel_onehot && sel_idx == exp_idx) begin
            capture_en = 1'b1;
            commit_req = (exp_idx == 4'd11);
        end else if (!(sel_onehot && sel_idx == prev_idx)) begin
            seq_err = 1'b1;
        end
    end

    assign last_xfer = out_valid && out_ready && (out_pos == 4'd11);
    assign commit_ok = commit_req && (!out_valid || last_xfer);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            sel_q     <= '0;
            segm_q    <= '0;
            exp_idx   <= '0;
            locked    <= 1'b0;
            out_valid <= 1'b0;
            out_pos   <= '0;
            err_flags <= '0;
            for (int k = 0; k < 12; k++) begin
                cap_buf[k] <= '0;
                out_buf[k] <= '0;
            end
        end else begin
            sel_q  <= sel;
            segm_q <= segm;

            if (capture_en) cap_buf[exp_idx] <= glyph;

            case (state)
                SYNC: begin
                    if (capture_en) begin
                        exp_idx <= 4'd1;
                        state   <= CAPTURE;
                        locked  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (seq_err) begin
                        exp_idx <= 4'd0;
                        state   <= SYNC;
                        locked  <= 1'b0;
                    end else if (capture_en) begin
                        exp_idx <= commit_req ? 4'd0 : exp_idx + 4'd1;
                    end
                end
                default: state <= SYNC;
            endcase

            // Position 11 is written into the buffer in this same cycle, so
            // the commit takes it straight from the decoder.
            if (commit_ok) begin
                for (int k = 0; k < 12; k++) begin
                    out_buf[k] <= (k == 11) ? glyph : cap_buf[k];
                end
                out_valid <= 1'b1;
                out_pos   <= 4'd0;
            end else if (out_valid && out_ready) begin
                if (out_pos == 4'd11) begin
                    out_valid <= 1'b0;
                    out_pos   <= 4'd0;
                end else begin
                    out_pos <= out_pos + 4'd1;
                end
            end

            err_flags <= (err_clr ? 3'b000 : err_flags)
                       | {commit_req && !commit_ok, capture_en && !glyph_known, seq_err};
        end
    end

    assign out_char = out_buf[out_pos];
    assign out_last = (out_pos == 4'd11);

endmodule

// File: doc/ita_scan_decoder.md
# ita_scan_decoder

Receive-side companion to the 12-digit, 14-segment multiplexed display driver. The block samples the driver's one-hot digit select and segment pattern, locks onto the scan sequence, and decodes each glyph back to ASCII. Each complete 12-digit frame is streamed out over a valid/ready character interface. It sits on the board-test / loopback path, so display text can be checked without optics.

## Interface
- `GLYPH_UNKNOWN`, default 8'h3F: ASCII code emitted for any unrecognised segment pattern.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sel`  in  12  digit select from the driver; bit k = digit k; one-hot, or all-zero meaning blank.
- `segm`  in  14  segment pattern for the selected digit.
- `out_ready`  in  1  consumer accepts `out_char` when `out_valid` is also high.
- `err_clr`  in  1  synchronous clear of `err_flags`.
- `out_valid`  out  1  a character is presented.
- `out_char`  out  8  ASCII code.
- `out_pos`  out  4  digit position 0..11 of `out_char`.
- `out_last`  out  1  high with position 11.
- `locked`  out  1  capture FSM is in CAPTURE.
- `err_flags`  out  3  sticky flags: [0] sequence error, [1] unknown glyph, [2] frame overrun.

## Operation
- Input stage: `sel` and `segm` are registered once before any use.
- Glyph decode (combinational on the registered `segm`):
  - 11101111000000 → 'A' 0x41
  - 10011100000000 → 'C' 0x43
  - 10011110000000 → 'E' 0x45
  - 10010000010010 → 'I' 0x49
  - 01101100101000 → 'M' 0x4D
  - 01101100100100 → 'N' 0x4E
  - 10000000010010 → 'T' 0x54
  - 00000000000000 → ' ' 0x20
  - anything else → `GLYPH_UNKNOWN`, and set `err_flags[1]` if the word is captured.
- Capture FSM, states SYNC and CAPTURE. Uses a 4-bit expected index `exp` and a 12×8 capture buffer.
  - SYNC: ignore inputs until registered `sel`==12'h001. Then store the char at position 0, set exp=1, go to CAPTURE.
  - CAPTURE, `sel` one-hot with index==exp: store the char at position exp.
    - If exp<11: exp++.
    - If exp==11: commit the frame and set exp=0. Stay in CAPTURE.
  - CAPTURE, `sel` one-hot with index==exp-1 (mod 12): held digit; ignore.
  - CAPTURE, any other value (wrong index, multi-hot, or zero): set `err_flags[0]`, go to SYNC. The partial frame is discarded.
- Commit: copy the capture buffer to the 12×8 output buffer and start a drain at position 0. This happens only if the output buffer is idle, or its last beat (pos 11) is accepted in the same cycle. Otherwise drop the frame and set `err_flags[2]`.
- Drain: present chars for positions 0..11 in order. A beat transfers when `out_valid`&&`out_ready`; `out_pos` then increments. After the pos-11 transfer, the output buffer goes idle.
- `out_char`, `out_pos` and `out_last` are stable while `out_valid` is high and `out_ready` is low.
- `err_flags` bits are sticky. `err_clr` clears them. If a flag is set in the same cycle as `err_clr`, the set wins.

## Timing
- Reset values: `out_valid`=0, `out_char`=0, `out_pos`=0, `out_last`=0, `locked`=0, `err_flags`=0; FSM in SYNC; exp=0; both buffers cleared to 0. Reset asserted mid-frame or mid-drain aborts immediately with no partial output.
- Latency: the pos-11 digit is sampled at edge t. Commit happens at edge t+1, and `out_valid` is high from t+1.
- With `out_ready` held at 1, the beat at pos k transfers at edge t+2+k.
- At the full driver rate (one digit per clock) and `out_ready` held at 1, frames stream gaplessly. The next commit, at t+13, coincides with the pos-11 transfer, so no overrun occurs.
- `locked` is high in every cycle the FSM is in CAPTURE.

## Test plan
- Reset, then drive the driver's 12-cycle scan of "TECNM ITA   " with `out_ready`=1 → 12 beats: 0x54,0x45,0x43,0x4E,0x4D,0x20,0x49,0x54,0x41,0x20,0x20,0x20; `out_last` only on pos 11; `err_flags`=0.
- Start the scan at digit 5 → no output until a digit-0 sample occurs; the first full frame then decodes correctly; `err_flags[0]`=0.
- Skip digit 7 (jump 6→8) → `err_flags[0]`=1, `locked` drops for one or more cycles, nothing is emitted for that frame; the next full frame is emitted.
- Hold `out_ready`=0 for 30 cycles during continuous scanning → the first frame's pos-0 beat is held stable throughout; `err_flags[2]`=1; after release, exactly that first frame's 12 beats are emitted.
- `segm`=14'h3FFF at pos 2 → `out_char`=0x3F at pos 2 and `err_flags[1]`=1; pulsing `err_clr` returns `err_flags` to 0.
- Assert `rst` during drain at pos 4 → `out_valid`=0 immediately; after release, output resumes only from the next complete frame.
